// File: rtl/alineador_if.sv
// alineador_if: serial-in / framed-symbol-out bundle for the comma aligner
interface alineador_if;
  logic       ENB;
  logic       in_serial;
  logic [9:0] out_10b;
  logic       valid;
  logic       comma;
  logic       sync;
  modport master (output ENB, in_serial, input out_10b, valid, comma, sync);
  modport slave  (input ENB, in_serial, output out_10b, valid, comma, sync);
endinterface

// File: rtl/alineador.sv
// alineador: K28.5 comma search and 10b symbol-boundary lock for a 1-bit serial line
module alineador #(
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 2
) (
  input logic       CLK,
  input logic       reset,
  alineador_if.slave bus
);
  localparam logic [1:0] SEARCH = 2'd0, CHECK = 2'd1, LOCKED = 2'd2;
  localparam logic [9:0] K_NEG = 10'b0011111010, K_POS = 10'b1100000101;
  logic [9:0] win_q, win_d, out_q;
  logic [3:0] bit_q, bit_d;
  logic [1:0] st_q, st_d, err_q, err_d, err_inc;
  logic [2:0] good_q, good_d, good_inc;
  logic       valid_q, comma_q, hit, on_bnd, realign, emit;
  always_comb begin
    win_d    = {win_q[8:0], bus.in_serial};
    hit      = win_d == K_NEG || win_d == K_POS;
    on_bnd   = bit_q == 4'd9;
    good_inc = good_q + 3'd1;
    err_inc  = err_q + 2'd1;
    st_d     = st_q;
    good_d   = good_q;
    err_d    = err_q;
    realign  = 1'b0;
    if (hit) begin
      if (st_q == SEARCH) begin
        realign = 1'b1;
        good_d  = 3'd1;
        err_d   = 2'd0;
        st_d    = LOCK_CNT == 1 ? LOCKED : CHECK;
      end else if (st_q == CHECK) begin
        if (on_bnd) begin
          good_d = good_inc;
          if (int'(good_q) + 1 >= LOCK_CNT) begin
            st_d  = LOCKED;
            err_d = 2'd0;
          end
        end else begin
          realign = 1'b1;
          good_d  = 3'd1;
        end
      end else if (on_bnd) begin
        err_d = 2'd0;
      end else if (int'(err_q) + 1 >= LOSS_CNT) begin
        // loss of lock re-anchors on the offending comma instead of going back to SEARCH
        realign = 1'b1;
        good_d  = 3'd1;
        err_d   = 2'd0;
        st_d    = CHECK;
      end else begin
        err_d = err_inc;
      end
    end
    bit_d = realign || on_bnd ? 4'd0 : bit_q + 4'd1;
    emit  = st_q != SEARCH && bit_q == 4'd0;
  end
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      win_q   <= '0;
      bit_q   <= '0;
      st_q    <= SEARCH;
      good_q  <= '0;
      err_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      comma_q <= 1'b0;
    end else if (bus.ENB) begin
      win_q   <= win_d;
      bit_q   <= bit_d;
      st_q    <= st_d;
      good_q  <= good_d;
      err_q   <= err_d;
      valid_q <= emit;
      comma_q <= emit && (win_q == K_NEG || win_q == K_POS);
      if (emit) out_q <= win_q;
    end else begin
      valid_q <= 1'b0;
      comma_q <= 1'b0;
    end
  end
  assign bus.out_10b = out_q;
  assign bus.valid   = valid_q;
  assign bus.comma   = comma_q;
  assign bus.sync    = st_q == LOCKED;
endmodule

// File: tb/tb_alineador.sv
// tb_alineador: directed lock/loss/stall/reset scenarios plus random stream against an edge-count model
module tb_alineador;
  logic CLK = 1'b0;
  logic reset = 1'b0;
  alineador_if bus ();
  alineador dut (.CLK(CLK), .reset(reset), .bus(bus.slave));
  always #5 CLK = ~CLK;

  localparam logic [9:0] KN = 10'b0011111010, KP = 10'b1100000101, D215 = 10'b1010101010;
  localparam int LOCK = 3, LOSS = 2;

  int checks = 0, errors = 0, cyc = 0, c0 = 0;
  // model: alignment is an absolute edge index (anchor); a boundary is any multiple of 10 past it
  int m_st, m_e, m_anchor, m_good, m_err;
  logic [9:0] m_win, m_out, s;
  logic m_valid, m_comma;
  int r;

  function automatic bit is_k(logic [9:0] w);
    return w == KN || w == KP;
  endfunction

  task automatic chk(string tag, logic [9:0] got, logic [9:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_st = 0; m_e = 0; m_anchor = 0; m_good = 0; m_err = 0;
    m_win = '0; m_out = '0; m_valid = 1'b0; m_comma = 1'b0;
  endtask

  task automatic m_edge(logic b, logic en);
    bit on;
    if (!en) begin
      m_valid = 1'b0;
      m_comma = 1'b0;
      return;
    end
    m_valid = m_st != 0 && (m_e - m_anchor) % 10 == 0;
    m_comma = m_valid && is_k(m_win);
    if (m_valid) m_out = m_win;
    m_win = {m_win[8:0], b};
    m_e++;
    if (is_k(m_win)) begin
      on = (m_e - m_anchor) % 10 == 0;
      if (m_st == 0) begin
        m_anchor = m_e; m_good = 1; m_st = LOCK == 1 ? 2 : 1;
      end else if (m_st == 1) begin
        if (on) begin
          m_good++;
          if (m_good >= LOCK) begin m_st = 2; m_err = 0; end
        end else begin
          m_anchor = m_e; m_good = 1;
        end
      end else if (on) begin
        m_err = 0;
      end else begin
        m_err++;
        if (m_err >= LOSS) begin m_anchor = m_e; m_good = 1; m_st = 1; end
      end
    end
  endtask

  task automatic step(logic b, logic en);
    bus.in_serial = b;
    bus.ENB = en;
    @(posedge CLK);
    if (reset) m_edge(b, en);
    cyc++;
    #1;
    chk("out_10b", bus.out_10b, m_out);
    chk("valid", 10'(bus.valid), 10'(m_valid));
    chk("comma", 10'(bus.comma), 10'(m_comma));
    chk("sync", 10'(bus.sync), 10'(m_st == 2));
  endtask

  task automatic send_bits(logic [9:0] sym, int hi);
    for (int j = hi; j >= 0; j--) step(sym[j], 1'b1);
  endtask

  initial begin
    bus.ENB = 1'b0;
    bus.in_serial = 1'b0;
    m_reset();
    for (int i = 0; i < 12; i++) step(1'($urandom), 1'b1);
    chk("rst_out", bus.out_10b, 10'h000);
    chk("rst_sync", 10'(bus.sync), 10'(0));
    reset = 1'b1;
    // acquire lock
    step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1);
    send_bits(KN, 9);
    chk("acq_sync_c1", 10'(bus.sync), 10'(0));
    step(D215[9], 1'b1);
    chk("acq_c1_out", bus.out_10b, KN);
    chk("acq_c1_valid", 10'(bus.valid), 10'(1));
    chk("acq_c1_comma", 10'(bus.comma), 10'(1));
    send_bits(D215, 8);
    step(KP[9], 1'b1);
    chk("acq_d_out", bus.out_10b, D215);
    chk("acq_d_valid", 10'(bus.valid), 10'(1));
    chk("acq_d_comma", 10'(bus.comma), 10'(0));
    send_bits(KP, 8);
    chk("acq_sync_c2", 10'(bus.sync), 10'(0));
    send_bits(KN, 9);
    chk("acq_sync_c3", 10'(bus.sync), 10'(1));
    // stall mid-symbol while locked
    step(D215[9], 1'b1);
    c0 = cyc;
    chk("lock_c3_out", bus.out_10b, KN);
    chk("lock_c3_valid", 10'(bus.valid), 10'(1));
    for (int j = 8; j >= 6; j--) step(D215[j], 1'b1);
    for (int i = 0; i < 7; i++) begin
      step(1'($urandom), 1'b0);
      chk("stall_valid", 10'(bus.valid), 10'(0));
    end
    send_bits(D215, 5);
    step(KN[9], 1'b1);
    chk("stall_out", bus.out_10b, D215);
    chk("stall_valid_after", 10'(bus.valid), 10'(1));
    chk("stall_gap", 10'(cyc - c0), 10'(17));
    send_bits(KN, 8);
    // one-bit slip: two off-boundary commas drop lock
    step(1'b0, 1'b1);
    send_bits(KN, 9);
    chk("loss_first_sync", 10'(bus.sync), 10'(1));
    send_bits(D215, 9);
    send_bits(KN, 9);
    chk("loss_second_sync", 10'(bus.sync), 10'(0));
    step(D215[9], 1'b1);
    chk("loss_out", bus.out_10b, KN);
    chk("loss_comma", 10'(bus.comma), 10'(1));
    send_bits(D215, 8);
    send_bits(KN, 9);
    chk("relock_c2_sync", 10'(bus.sync), 10'(0));
    send_bits(D215, 9);
    send_bits(KN, 9);
    chk("relock_sync", 10'(bus.sync), 10'(1));
    // asynchronous reset while locked and valid
    step(D215[9], 1'b1);
    chk("pre_rst_valid", 10'(bus.valid), 10'(1));
    #1 reset = 1'b0;
    m_reset();
    #1;
    chk("arst_sync", 10'(bus.sync), 10'(0));
    chk("arst_valid", 10'(bus.valid), 10'(0));
    chk("arst_out", bus.out_10b, 10'h000);
    for (int i = 0; i < 3; i++) step(1'($urandom), 1'b1);
    reset = 1'b1;
    // misaligned comma in CHECK re-anchors the phase
    send_bits(KN, 9);
    step(1'b0, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b0, 1'b1);
    send_bits(KN, 9);
    send_bits(D215, 9);
    send_bits(KN, 9);
    chk("realign_nosync", 10'(bus.sync), 10'(0));
    send_bits(D215, 9);
    send_bits(KN, 9);
    chk("realign_sync", 10'(bus.sync), 10'(1));
    // random symbol stream with slips and enable gaps
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 9);
      s = r < 3 ? KN : r < 5 ? KP : r < 7 ? D215 : 10'($urandom);
      if (r == 9) step(1'($urandom), 1'b1);
      for (int j = 9; j >= 0; j--) begin
        if ($urandom_range(0, 15) == 0) step(1'($urandom), 1'b0);
        step(s[j], 1'b1);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
